// File: rtl/gravsim_pkg.sv
// Shared types and constants for the gravity-sim ball parameter path.
package gravsim_pkg;

    typedef enum logic [1:0] {IDLE, ARMED, COPY, DONE} sched_state_t;

    localparam int WORDS_PER_BALL = 4;

    localparam logic [3:0] ADDR_CTRL   = 4'd8;
    localparam logic [3:0] ADDR_STATUS = 4'd9;
    localparam logic [3:0] ADDR_FRAME  = 4'd10;

    // Per-byte merge of an Avalon write into an existing word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  byte_en);
        logic [31:0] result;
        for (int b = 0; b < 4; b++)
            result[b*8 +: 8] = byte_en[b] ? new_word[b*8 +: 8] : old_word[b*8 +: 8];
        return result;
    endfunction

endpackage

// File: rtl/vs_fall_detect.sv
// Synchronizes the active-low vertical sync and flags its falling edge.
module vs_fall_detect (
    input  logic CLK,
    input  logic RESET,
    input  logic VGA_VS,
    output logic vs_fall
);

    logic sync1, synced, delayed;

    // Resetting to 0 means a sync already low at reset never looks like a fall.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1   <= 1'b0;
            synced  <= 1'b0;
            delayed <= 1'b0;
        end else begin
            sync1   <= VGA_VS;
            synced  <= sync1;
            delayed <= synced;
        end
    end

    assign vs_fall = delayed & ~synced;

endmodule

// File: rtl/ball_param_scheduler.sv
// Double-buffered ball parameter bank: Avalon writes land in staging and are
// copied into the live bank one word per clock after the next VS falling edge.
module ball_param_scheduler import gravsim_pkg::*; #(
    parameter  int NUM_BALLS = 2,
    localparam int NWORDS    = NUM_BALLS * WORDS_PER_BALL
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                AVL_READ,
    input  logic                AVL_WRITE,
    input  logic                AVL_CS,
    input  logic [3:0]          AVL_BYTE_EN,
    input  logic [3:0]          AVL_ADDR,
    input  logic [31:0]         AVL_WRITEDATA,
    output logic [31:0]         AVL_READDATA,
    input  logic                VGA_VS,
    output logic [NWORDS*32-1:0] LIVE_PARAMS,
    output logic                COMMIT_DONE,
    output logic                BUSY
);

    localparam int                IDX_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [3:0]        NWORDS_A = 4'(NWORDS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NWORDS - 1);

    logic [31:0]      staging [NWORDS];
    logic [31:0]      live    [NWORDS];
    sched_state_t     state;
    logic [IDX_W-1:0] idx;
    logic             pending;
    logic [7:0]       commit_count;
    logic [31:0]      frame_count;
    logic             vs_fall;

    logic wr_en, rd_en, stage_wr, ctrl_set;

    assign wr_en    = AVL_CS & AVL_WRITE;
    assign rd_en    = AVL_CS & AVL_READ;
    assign stage_wr = wr_en && (AVL_ADDR < NWORDS_A);
    assign ctrl_set = wr_en && (AVL_ADDR == ADDR_CTRL) && AVL_BYTE_EN[0] && AVL_WRITEDATA[0];

    vs_fall_detect u_vs_fall_detect (
        .CLK     (CLK),
        .RESET   (RESET),
        .VGA_VS  (VGA_VS),
        .vs_fall (vs_fall)
    );

    // NOTE: the banks are small register files, so every word gets an explicit reset;
    // a RAM-mapped bank would have to be cleared by a sweep instead.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NWORDS; i++) staging[i] <= '0;
        end else if (stage_wr) begin
            staging[AVL_ADDR[IDX_W-1:0]] <= merge_bytes(staging[AVL_ADDR[IDX_W-1:0]],
                                                        AVL_WRITEDATA, AVL_BYTE_EN);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) frame_count <= '0;
        else if (vs_fall) frame_count <= frame_count + 32'd1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= IDLE;
            idx          <= '0;
            pending      <= 1'b0;
            commit_count <= '0;
            COMMIT_DONE  <= 1'b0;
            BUSY         <= 1'b0;
            for (int i = 0; i < NWORDS; i++) live[i] <= '0;
        end else begin
            COMMIT_DONE <= 1'b0;
            case (state)
                IDLE: if (pending) begin
                    state <= ARMED;
                    BUSY  <= 1'b1;
                end
                ARMED: if (vs_fall) begin
                    pending <= 1'b0;
                    idx     <= '0;
                    state   <= COPY;
                end
                COPY: begin
                    live[idx] <= staging[idx];
                    idx       <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state        <= DONE;
                        COMMIT_DONE  <= 1'b1;
                        commit_count <= commit_count + 8'd1;
                    end
                end
                DONE: if (pending || ctrl_set) begin
                    state <= ARMED;
                end else begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            // NOTE: this non-blocking assignment comes after the clear in ARMED, so a
            // CTRL write in the consuming cycle wins and pending stays set.
            if (ctrl_set) pending <= 1'b1;
        end
    end

    // NOTE: AVL_READDATA gets a default before any branch so this stays purely
    // combinational with no latch on unmapped addresses.
    always_comb begin
        AVL_READDATA = '0;
        if (rd_en) begin
            if (AVL_ADDR < NWORDS_A) begin
                AVL_READDATA = staging[AVL_ADDR[IDX_W-1:0]];
            end else begin
                case (AVL_ADDR)
                    ADDR_STATUS: AVL_READDATA = {16'h0, commit_count, 6'h0, (state == COPY), pending};
                    ADDR_FRAME:  AVL_READDATA = frame_count;
                    default:     AVL_READDATA = '0;
                endcase
            end
        end
    end

    for (genvar i = 0; i < NWORDS; i++) begin : g_live
        assign LIVE_PARAMS[i*32 +: 32] = live[i];
    end

endmodule

// File: tb/tb_ball_param_scheduler.sv
// Directed bench for ball_param_scheduler: a timeline-based model of the commit
// schedule is compared every cycle, with literal checks pinning key moments.
module tb_ball_param_scheduler;

    localparam int NB = 2;
    localparam int NW = NB * 4;

    logic           CLK = 1'b0;
    logic           RESET;
    logic           AVL_READ, AVL_WRITE, AVL_CS;
    logic [3:0]     AVL_BYTE_EN, AVL_ADDR;
    logic [31:0]    AVL_WRITEDATA, AVL_READDATA;
    logic           VGA_VS;
    logic [NW*32-1:0] LIVE_PARAMS;
    logic           COMMIT_DONE, BUSY;

    ball_param_scheduler #(.NUM_BALLS(NB)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .AVL_READ      (AVL_READ),
        .AVL_WRITE     (AVL_WRITE),
        .AVL_CS        (AVL_CS),
        .AVL_BYTE_EN   (AVL_BYTE_EN),
        .AVL_ADDR      (AVL_ADDR),
        .AVL_WRITEDATA (AVL_WRITEDATA),
        .AVL_READDATA  (AVL_READDATA),
        .VGA_VS        (VGA_VS),
        .LIVE_PARAMS   (LIVE_PARAMS),
        .COMMIT_DONE   (COMMIT_DONE),
        .BUSY          (BUSY)
    );

    always #10 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Model: commits are tracked by the edge number at which copying starts;
    // word k is copied k+1 edges later and the pulse follows the last word.
    int          edge_n = 0;
    bit          model_ready = 0;
    logic [31:0] m_stage [NW];
    logic [31:0] m_live  [NW];
    bit          m_pending, m_armed, m_done;
    int          m_start;
    logic [31:0] m_frames;
    logic [7:0]  m_commits;
    bit          vs_a, vs_b, vs_c;
    bit          m_fall, m_wr, m_ctrl;
    int          m_k;

    always @(posedge CLK) begin
        edge_n++;
        if (RESET) begin
            for (int i = 0; i < NW; i++) begin
                m_stage[i] = '0;
                m_live[i]  = '0;
            end
            m_pending = 0; m_armed = 0; m_done = 0; m_start = -1;
            m_frames = '0; m_commits = '0;
            vs_a = 0; vs_b = 0; vs_c = 0;
            model_ready = 1;
        end else begin
            m_fall = vs_c & ~vs_b;
            m_wr   = AVL_CS & AVL_WRITE;
            m_ctrl = m_wr && AVL_ADDR == 4'd8 && AVL_BYTE_EN[0] && AVL_WRITEDATA[0];
            m_done = 0;
            if (m_fall) m_frames = m_frames + 1;
            if (m_start >= 0) begin
                m_k = edge_n - m_start - 1;
                if (m_k >= 0 && m_k < NW) m_live[m_k] = m_stage[m_k];
                if (edge_n == m_start + NW) begin
                    m_done = 1;
                    m_commits = m_commits + 1;
                end
                if (edge_n == m_start + NW + 1) begin
                    m_start = -1;
                    m_armed = m_pending || m_ctrl;
                end
            end else if (m_armed) begin
                if (m_fall) begin
                    m_start = edge_n;
                    m_armed = 0;
                    m_pending = 0;
                end
            end else if (m_pending) begin
                m_armed = 1;
            end
            if (m_ctrl) m_pending = 1;
            if (m_wr && AVL_ADDR < 4'(NW))
                for (int b = 0; b < 4; b++)
                    if (AVL_BYTE_EN[b]) m_stage[AVL_ADDR[2:0]][b*8 +: 8] = AVL_WRITEDATA[b*8 +: 8];
            vs_c = vs_b; vs_b = vs_a; vs_a = VGA_VS;
        end
    end

    function automatic logic m_in_copy();
        return (m_start >= 0) && (edge_n - m_start < NW);
    endfunction

    function automatic logic [31:0] exp_read(input logic [3:0] a);
        if (a < 4'(NW)) return m_stage[a[2:0]];
        case (a)
            4'd9:    return {16'h0, m_commits, 6'h0, m_in_copy(), m_pending};
            4'd10:   return m_frames;
            default: return 32'h0;
        endcase
    endfunction

    always @(negedge CLK) begin
        if (model_ready) begin
            for (int i = 0; i < NW; i++)
                check($sformatf("live[%0d]", i), LIVE_PARAMS[i*32 +: 32], m_live[i]);
            check("busy", {31'h0, BUSY}, {31'h0, m_armed || (m_start >= 0)});
            check("commit_done", {31'h0, COMMIT_DONE}, {31'h0, m_done});
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic avl_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = a; AVL_WRITEDATA = d; AVL_BYTE_EN = be;
        tick();
        AVL_CS = 0; AVL_WRITE = 0; AVL_BYTE_EN = 4'h0;
    endtask

    task automatic avl_read(input logic [3:0] a, input string name, input bit use_lit,
                            input logic [31:0] lit);
        AVL_CS = 1; AVL_READ = 1; AVL_ADDR = a;
        @(negedge CLK);
        check({name, "/model"}, AVL_READDATA, exp_read(a));
        if (use_lit) check(name, AVL_READDATA, lit);
        @(posedge CLK);
        #1;
        AVL_CS = 0; AVL_READ = 0;
    endtask

    function automatic logic [31:0] live_word(input int i);
        return LIVE_PARAMS[i*32 +: 32];
    endfunction

    initial begin
        RESET = 1; AVL_READ = 0; AVL_WRITE = 0; AVL_CS = 0;
        AVL_BYTE_EN = 0; AVL_ADDR = 0; AVL_WRITEDATA = 0; VGA_VS = 1;
        ticks(2);
        RESET = 0;
        ticks(2);

        // Reset clears staging and all registers
        avl_write(4'd1, 32'h140, 4'hF);
        avl_read(4'd1, "stage1_pre_reset", 1, 32'h140);
        RESET = 1;
        ticks(2);
        RESET = 0;
        tick();
        for (int a = 0; a <= 10; a++)
            avl_read(4'(a), $sformatf("reset_rd%0d", a), 1, 32'h0);
        check("reset_busy", {31'h0, BUSY}, 32'h0);
        for (int i = 0; i < NW; i++) check("reset_live", live_word(i), 32'h0);

        // Byte enables
        avl_write(4'd5, 32'hAABBCCDD, 4'hF);
        avl_write(4'd5, 32'h11223344, 4'b0101);
        avl_read(4'd5, "byte_en", 1, 32'hAA22CC44);
        avl_write(4'd12, 32'hDEADBEEF, 4'hF);
        avl_read(4'd12, "unmapped_rd", 1, 32'h0);

        // Tear-free: frames counted, nothing copied without a commit
        avl_write(4'd2, 32'h55, 4'hF);
        for (int t = 0; t < 3; t++) begin
            VGA_VS = 0; ticks(4);
            VGA_VS = 1; ticks(4);
        end
        check("tearfree_live2", live_word(2), 32'h0);
        avl_read(4'd10, "frame_count3", 1, 32'd3);

        // Basic commit with exact timing
        for (int k = 0; k < NW; k++) avl_write(4'(k), 32'h10 + 32'(k), 4'hF);
        avl_write(4'd8, 32'h1, 4'h1);
        tick();
        check("armed_busy", {31'h0, BUSY}, 32'h1);
        VGA_VS = 0;
        ticks(10);                                     // just after E+9
        check("e9_live6", live_word(6), 32'h16);
        check("e9_live7", live_word(7), 32'h0);
        check("e9_done", {31'h0, COMMIT_DONE}, 32'h0);
        tick();                                        // just after E+10
        check("e10_done", {31'h0, COMMIT_DONE}, 32'h1);
        check("e10_live7", live_word(7), 32'h17);
        tick();
        check("e11_done", {31'h0, COMMIT_DONE}, 32'h0);
        avl_read(4'd9, "status_after_commit", 1, 32'h0000_0100);
        avl_read(4'd10, "frame_count4", 1, 32'd4);
        VGA_VS = 1;
        ticks(4);

        // Re-arm: CTRL written during COPY
        for (int k = 0; k < NW; k++) avl_write(4'(k), 32'h20 + 32'(k), 4'hF);
        avl_write(4'd8, 32'h1, 4'h1);
        ticks(2);
        VGA_VS = 0;
        ticks(5);                                      // just after E+4
        avl_write(4'd8, 32'h1, 4'h1);                  // lands at E+5, in COPY
        ticks(6);                                      // just after E+11
        check("rearm_busy", {31'h0, BUSY}, 32'h1);
        avl_read(4'd9, "status_rearmed", 1, 32'h0000_0201);
        check("rearm_live0", live_word(0), 32'h20);
        avl_write(4'd0, 32'h99, 4'hF);
        VGA_VS = 1;
        ticks(4);
        VGA_VS = 0;
        ticks(6);                                      // just after E2+5
        avl_write(4'd3, 32'h77, 4'hF);                 // same edge as word 3 copy
        ticks(4);                                      // just after E2+10
        check("second_done", {31'h0, COMMIT_DONE}, 32'h1);
        check("second_live0", live_word(0), 32'h99);
        check("second_live3", live_word(3), 32'h23);
        check("second_live7", live_word(7), 32'h27);
        tick();
        avl_read(4'd9, "status_second", 1, 32'h0000_0300);
        avl_read(4'd3, "stage3_new", 1, 32'h77);
        VGA_VS = 1;
        ticks(4);

        // Reset in the middle of a copy
        avl_write(4'd8, 32'h1, 4'h1);
        ticks(2);
        VGA_VS = 0;
        ticks(5);                                      // just after E+4
        RESET = 1;
        tick();                                        // reset sampled at E+5
        RESET = 0;
        check("midreset_busy", {31'h0, BUSY}, 32'h0);
        for (int i = 0; i < NW; i++) check("midreset_live", live_word(i), 32'h0);
        for (int c = 0; c < 14; c++) begin
            tick();
            check("midreset_no_done", {31'h0, COMMIT_DONE}, 32'h0);
        end
        avl_read(4'd9, "midreset_status", 1, 32'h0);
        avl_read(4'd10, "midreset_frames", 1, 32'h0);
        VGA_VS = 1;
        ticks(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ball_param_scheduler.md
# ball_param_scheduler

Double-buffered, frame-synchronous parameter controller for the ball renderers. The Nios II writes ball parameters (radius, x, y, z per ball) into a staging bank over Avalon-MM and requests a commit. On the next vertical-sync falling edge, the block copies the staging bank into the live bank that drives the `ball` instances, one word per clock, so a frame never renders half-updated positions. It replaces direct regfile-to-ball wiring inside the Avalon slave.

## Interface

**Parameters**

- `NUM_BALLS`, default 2: number of ball instances served.
- `WORDS_PER_BALL`, fixed at 4: order is radius, posX, posY, posZ.
- `NWORDS` = `NUM_BALLS*WORDS_PER_BALL`: size of the staging/live bank. Must be ≤ 8 at address width 4.

**Ports**

- `CLK` in 1: 50 MHz; the single clock.
- `RESET` in 1: synchronous, active-high.
- `AVL_READ` in 1: Avalon-MM read.
- `AVL_WRITE` in 1: Avalon-MM write.
- `AVL_CS` in 1: chip select.
- `AVL_BYTE_EN` in 4: byte enables; any combination is honoured per byte.
- `AVL_ADDR` in 4: word address.
- `AVL_WRITEDATA` in 32: write data.
- `AVL_READDATA` out 32: combinational read data; 0 when not `AVL_CS && AVL_READ`.
- `VGA_VS` in 1: vertical sync from the VGA controller; active low.
- `LIVE_PARAMS` out `NWORDS`×32: live bank, word `i` = ball `i/4`, field `i%4`.
- `COMMIT_DONE` out 1: one-cycle pulse when a commit finishes.
- `BUSY` out 1: high in ARMED, COPY or DONE.

## Operation

**Address map**

- 0 .. `NWORDS`-1: staging bank, R/W.
- 8 CTRL: write with byte 0 enabled and bit0=1 sets `pending`. Reads return 0.
- 9 STATUS, RO: bit0 `pending`, bit1 state==COPY, bits[15:8] `commit_count`[7:0].
- 10 FRAME_COUNT, RO: 32-bit count of VS falling edges; wraps at 2^32.
- 11–15: reads 0; writes are ignored.

**VS edge detect**

- Two-flop synchronizer on `VGA_VS`, plus one delay flop.
- `vs_fall` = delayed & ~synced.
- `vs_fall` increments FRAME_COUNT every time, independent of FSM state.

**FSM**

- IDLE: if `pending`, go to ARMED.
- ARMED: on `vs_fall`, clear `pending`, set idx=0, go to COPY.
- COPY: each cycle `live[idx] <= staging[idx]` and idx++. When idx==`NWORDS`-1, go to DONE.
- DONE: assert `COMMIT_DONE`, increment `commit_count` (8-bit, wraps). Go to ARMED if `pending`, else IDLE.

**Boundary rules**

- Staging writes are accepted in every state.
- A copy takes the pre-edge staging value, so a write to word `idx` in the same cycle as its copy lands in the next commit.
- CTRL write while `pending` is already set: no effect.
- CTRL write during COPY or DONE: sets `pending` and triggers a re-arm after DONE.
- CTRL write in the same cycle ARMED consumes `vs_fall`: `pending` ends set (the set wins over the clear).
- `vs_fall` during COPY or DONE: counted in FRAME_COUNT only; does not restart the copy.

**Reset**

- RESET, including mid-COPY, forces state IDLE, idx 0, `pending` 0.
- Staging, live, FRAME_COUNT and `commit_count` all reset to 0.
- `COMMIT_DONE` and `BUSY` reset to 0.

## Timing

- Reads: zero-latency combinational, matching the existing slave.
- Writes: take effect at the next `CLK` edge.
- Let VGA_VS be sampled low at edge E:
  - `vs_fall` is high during the cycle after E+1.
  - ARMED→COPY at E+2.
  - Word k is copied at edge E+3+k.
  - DONE is entered at E+2+`NWORDS`; `COMMIT_DONE` is high in the following cycle.
  - State leaves DONE at E+3+`NWORDS`.
- With `NWORDS`=8, a commit takes 11 cycles from edge to completion, well inside the vertical blanking interval.
- `LIVE_PARAMS` is registered; each word changes only on its copy edge or on reset.

## Structure

- Shared package `gravsim_pkg`:
  - `sched_state_t` enum {IDLE, ARMED, COPY, DONE}.
  - Address constants ADDR_CTRL=8, ADDR_STATUS=9, ADDR_FRAME=10.
  - `WORDS_PER_BALL`.
- Sub-module `vs_fall_detect` (CLK, RESET, VGA_VS → `vs_fall`): the synchronizer plus edge flop.
- The top-level Avalon slave instantiates `ball_param_scheduler` and feeds `LIVE_PARAMS` slices to the `ball` instances.

## Test plan

- **Reset state:** write staging[1]=0x140, then RESET → all registers read 0, `LIVE_PARAMS` all 0, `BUSY`=0.
- **Basic commit:** write staging[0..7]=0x10..0x17, write CTRL=1, drop VGA_VS at edge E → `live[k]`=0x10+k at E+3+k, `COMMIT_DONE` high exactly one cycle after E+10, STATUS[15:8]=1.
- **Tear-free:** with no commit pending, write staging[2]=0x55 and toggle VGA_VS three times → `live[2]` unchanged, FRAME_COUNT=3.
- **Byte enables:** staging[5]=0xAABBCCDD, then write 0x11223344 with BYTE_EN=4'b0101 → reads 0xAA22CC44.
- **Re-arm:** CTRL=1 written during COPY → after DONE, state ARMED, STATUS bit0=1; next `vs_fall` performs a second copy, `commit_count`=2.
- **Reset mid-COPY:** assert RESET at E+5 → state IDLE, all live words 0, no `COMMIT_DONE` pulse.
